// File: rtl/ahb_lite_arbiter_2m_if.sv
// Bus bundle between the two AHB-Lite masters, the arbiter and the shared bus.
// slave: the arbiter's view; master: the masters plus slave-mux side.
interface ahb_lite_arbiter_2m_if;
    logic [1:0]       req_m;
    logic [1:0]       gnt_m;
    logic [1:0][31:0] haddr_m;
    logic [1:0][1:0]  htrans_m;
    logic [1:0]       hwrite_m;
    logic [1:0][2:0]  hsize_m;
    logic [1:0][2:0]  hburst_m;
    logic [1:0][3:0]  hprot_m;
    logic [1:0]       hmastlock_m;
    logic [1:0][31:0] hwdata_m;

    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [2:0]       hburst;
    logic [3:0]       hprot;
    logic             hmastlock;
    logic [31:0]      hwdata;
    logic             hready;
    logic             hmaster;

    modport slave (
        input  req_m, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m,
               hprot_m, hmastlock_m, hwdata_m, hready,
        output gnt_m, haddr, htrans, hwrite, hsize, hburst, hprot,
               hmastlock, hwdata, hmaster
    );

    modport master (
        output req_m, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m,
               hprot_m, hmastlock_m, hwdata_m, hready,
        input  gnt_m, haddr, htrans, hwrite, hsize, hburst, hprot,
               hmastlock, hwdata, hmaster
    );
endinterface

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: separate address/data-phase ownership, handover
// only at single-transfer or idle boundaries, with a per-owner transfer quota.
module ahb_lite_arbiter_2m #(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                 HCLK,
    input  logic                 RESET,
    ahb_lite_arbiter_2m_if.slave bus
);
    localparam int              CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic            DEF_OWN    = 1'(DEFAULT_MASTER);
    localparam logic [CNT_W:0]  HOLD_LIMIT = (CNT_W + 1)'(MAX_HOLD);
    localparam logic [1:0]      TR_IDLE    = 2'b00;
    localparam logic [1:0]      TR_NONSEQ  = 2'b10;
    localparam logic [2:0]      BURST_SGL  = 3'b000;

    logic             addr_own_q, addr_own_d;
    logic             data_own_q, data_own_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             oth_idx;
    logic             own_req, oth_req;
    logic [1:0]       own_trans;
    logic [2:0]       own_burst;
    logic             own_lock;
    logic             accept;
    logic             handover_ok;
    logic [CNT_W:0]   cnt_next;
    logic [CNT_W-1:0] cnt_sat;

    assign oth_idx   = ~addr_own_q;
    assign own_req   = bus.req_m[addr_own_q];
    assign oth_req   = bus.req_m[oth_idx];
    assign own_trans = bus.htrans_m[addr_own_q];
    assign own_burst = bus.hburst_m[addr_own_q];
    assign own_lock  = bus.hmastlock_m[addr_own_q];

    assign accept   = bus.hready & own_trans[1];
    assign cnt_next = {1'b0, hold_cnt_q} + {{CNT_W{1'b0}}, accept};
    assign cnt_sat  = (cnt_next >= HOLD_LIMIT) ? HOLD_LIMIT[CNT_W-1:0] : cnt_next[CNT_W-1:0];

    // SEQ/BUSY never qualify, so a burst is never split between masters.
    assign handover_ok = bus.hready
                       & ~(own_lock & (own_trans != TR_IDLE))
                       & ((own_trans == TR_IDLE)
                          | ((own_trans == TR_NONSEQ) & (own_burst == BURST_SGL)));

    always_comb begin
        addr_own_d = addr_own_q;
        hold_cnt_d = cnt_sat;
        if (handover_ok) begin
            if (oth_req && (!own_req || (cnt_next >= HOLD_LIMIT))) begin
                addr_own_d = oth_idx;
                hold_cnt_d = '0;
            end else if (!oth_req && !own_req && (addr_own_q != DEF_OWN)) begin
                addr_own_d = DEF_OWN;
                hold_cnt_d = '0;
            end
        end
        data_own_d = bus.hready ? addr_own_q : data_own_q;
    end

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            addr_own_q <= DEF_OWN;
            data_own_q <= DEF_OWN;
            hold_cnt_q <= '0;
        end else begin
            addr_own_q <= addr_own_d;
            data_own_q <= data_own_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Grants come straight from the owner register: no REQ-to-GNT comb path.
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign bus.gnt_m[gi] = (addr_own_q == 1'(gi));
    end

    assign bus.haddr     = bus.haddr_m[addr_own_q];
    assign bus.htrans    = bus.htrans_m[addr_own_q];
    assign bus.hwrite    = bus.hwrite_m[addr_own_q];
    assign bus.hsize     = bus.hsize_m[addr_own_q];
    assign bus.hburst    = bus.hburst_m[addr_own_q];
    assign bus.hprot     = bus.hprot_m[addr_own_q];
    assign bus.hmastlock = bus.hmastlock_m[addr_own_q];
    assign bus.hwdata    = bus.hwdata_m[data_own_q];
    assign bus.hmaster   = data_own_q;
endmodule
